// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Per-register scoreboard hazard unit for the in-order MIPS pipeline.
//   Each GPR (except r0) holds a valid bit, the current stage of its
//   youngest in-flight writer (age 1=E .. NSTG=W) and the stage at which
//   that writer's result becomes available. From this the unit produces
//   the D-stage stall and the forwarding selects, then pipelines the
//   selects to the E and M consumers.
//
//   Optional feature macro: HAZARD_MD_EN
//     defined   : multiply/divide busy counter stalls HI/LO readers.
//     undefined : no counter, md_busy tied 0, md inputs ignored.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   rs_d, rt_d                  D-stage source indices
//   use_rs_d, use_rt_d          operand is actually read
//   need_rs_d, need_rt_d        consuming stage (0=D, 1=E, 2=M)
//   wen_d, dst_d, rdy_d         D writer: enable, destination, ready stage
//   use_md_d                    D instruction touches HI/LO
//   md_start_e, md_div_e        E-stage mult/div launch, divide select
//   stallf, stalld, flushe      common stall (freeze F/D, bubble E)
//   fwd_rs_d, fwd_rt_d          combinational D-stage selects
//   fwd_rs_e, fwd_rt_e          registered E-stage selects
//   fwd_rt_m                    registered M-stage select (store data)
//   md_busy                     md counter nonzero
//   Select encoding: 0 = register file, k = result held in stage k.
module hazard_scoreboard #(
  parameter int unsigned NREG    = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned NSTG    = 3,
  parameter int unsigned SW      = 2,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10,
  parameter int unsigned CW      = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rs_d,
  input  logic [AW-1:0] rt_d,
  input  logic          use_rs_d,
  input  logic          use_rt_d,
  input  logic [1:0]    need_rs_d,
  input  logic [1:0]    need_rt_d,
  input  logic          wen_d,
  input  logic [AW-1:0] dst_d,
  input  logic [SW-1:0] rdy_d,
  input  logic          use_md_d,
  input  logic          md_start_e,
  input  logic          md_div_e,
  output logic          stallf,
  output logic          stalld,
  output logic          flushe,
  output logic [SW-1:0] fwd_rs_d,
  output logic [SW-1:0] fwd_rt_d,
  output logic [SW-1:0] fwd_rs_e,
  output logic [SW-1:0] fwd_rt_e,
  output logic [SW-1:0] fwd_rt_m,
  output logic          md_busy
);

  logic [NREG-1:0]         sb_vld_q, sb_vld_d;
  logic [NREG-1:0][SW-1:0] sb_age_q, sb_age_d;
  logic [NREG-1:0][SW-1:0] sb_rdy_q, sb_rdy_d;

  logic [SW-1:0] fwd_rs_e_q, fwd_rs_e_d;
  logic [SW-1:0] fwd_rt_e_q, fwd_rt_e_d;
  logic [SW-1:0] rt_m_e_q, rt_m_e_d;     // M-consumer select while in E
  logic [SW-1:0] fwd_rt_m_q, fwd_rt_m_d;

  logic          rs_vld, rt_vld;
  logic          haz_rs, haz_rt;
  logic [SW-1:0] sel_rs, sel_rt;
  logic          md_hazard;
  logic          stall;
  logic          advance;

  // The producer has moved age+need stages by the time the consumer needs
  // the value; if that position is not yet past its ready stage we must
  // stall, otherwise forward from that stage (or the RF once retired).
  function automatic logic [SW:0] check_src(input logic          vld,
                                            input logic [SW-1:0] age,
                                            input logic [SW-1:0] rdy,
                                            input logic [1:0]    need);
    logic [SW:0]   sum;
    logic          haz;
    logic [SW-1:0] sel;
    sum = (SW+1)'(age) + (SW+1)'(need);
    haz = vld && (sum <= (SW+1)'(rdy));
    sel = '0;
    if (vld && !haz && (sum <= (SW+1)'(NSTG))) sel = sum[SW-1:0];
    return {haz, sel};
  endfunction

  always_comb begin
    rs_vld = use_rs_d && (rs_d != '0) && sb_vld_q[rs_d];
    rt_vld = use_rt_d && (rt_d != '0) && sb_vld_q[rt_d];
    {haz_rs, sel_rs} = check_src(rs_vld, sb_age_q[rs_d], sb_rdy_q[rs_d], need_rs_d);
    {haz_rt, sel_rt} = check_src(rt_vld, sb_age_q[rt_d], sb_rdy_q[rt_d], need_rt_d);
  end

  assign stall   = haz_rs | haz_rt | md_hazard;
  assign advance = ~stall;
  assign stallf  = stall;
  assign stalld  = stall;
  assign flushe  = stall;

  assign fwd_rs_d = (need_rs_d == 2'd0) ? sel_rs : '0;
  assign fwd_rt_d = (need_rt_d == 2'd0) ? sel_rt : '0;

  // Scoreboard next state: age every entry, retire at NSTG, then let a
  // same-edge allocation override whatever ageing did to that register.
  always_comb begin
    sb_vld_d = sb_vld_q;
    sb_age_d = sb_age_q;
    sb_rdy_d = sb_rdy_q;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (sb_vld_q[i]) begin
        if (sb_age_q[i] == SW'(NSTG)) sb_vld_d[i] = 1'b0;
        else                          sb_age_d[i] = sb_age_q[i] + SW'(1);
      end
    end
    if (advance && wen_d && (dst_d != '0)) begin
      sb_vld_d[dst_d] = 1'b1;
      sb_age_d[dst_d] = SW'(1);
      sb_rdy_d[dst_d] = rdy_d;
    end
    sb_vld_d[0] = 1'b0;
  end

  always_comb begin
    fwd_rs_e_d = '0;
    fwd_rt_e_d = '0;
    rt_m_e_d   = '0;
    if (advance) begin
      if (need_rs_d == 2'd1) fwd_rs_e_d = sel_rs;
      if (need_rt_d == 2'd1) fwd_rt_e_d = sel_rt;
      if (need_rt_d == 2'd2) rt_m_e_d   = sel_rt;
    end
    fwd_rt_m_d = rt_m_e_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_vld_q   <= '0;
      sb_age_q   <= '0;
      sb_rdy_q   <= '0;
      fwd_rs_e_q <= '0;
      fwd_rt_e_q <= '0;
      rt_m_e_q   <= '0;
      fwd_rt_m_q <= '0;
    end else begin
      sb_vld_q   <= sb_vld_d;
      sb_age_q   <= sb_age_d;
      sb_rdy_q   <= sb_rdy_d;
      fwd_rs_e_q <= fwd_rs_e_d;
      fwd_rt_e_q <= fwd_rt_e_d;
      rt_m_e_q   <= rt_m_e_d;
      fwd_rt_m_q <= fwd_rt_m_d;
    end
  end

  assign fwd_rs_e = fwd_rs_e_q;
  assign fwd_rt_e = fwd_rt_e_q;
  assign fwd_rt_m = fwd_rt_m_q;

`ifdef HAZARD_MD_EN
  logic [CW-1:0] md_cnt_q, md_cnt_d;

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_start_e)             md_cnt_d = md_div_e ? CW'(DIV_LAT) : CW'(MUL_LAT);
    else if (md_cnt_q != '0)    md_cnt_d = md_cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) md_cnt_q <= '0;
    else        md_cnt_q <= md_cnt_d;
  end

  assign md_hazard = use_md_d & (md_start_e | (md_cnt_q != '0));
  assign md_busy   = (md_cnt_q != '0);
`else
  logic unused_md;
  assign unused_md = ^{use_md_d, md_start_e, md_div_e, CW'(MUL_LAT), CW'(DIV_LAT)};
  assign md_hazard = 1'b0;
  assign md_busy   = 1'b0;
`endif

endmodule
